// File: rtl/lms_pkg.sv
// Shared definitions for the LMS sample path.
// Sample width, buffer depth and align FSM encoding.
package lms_pkg;

  localparam int W1     = 12;
  localparam int DEPTH  = 8;
  localparam int SKEW_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    DISCARD = 2'd2
  } align_st_e;

endpackage

// File: rtl/lms_sample_feeder_if.sv
// Sample/pair bundle between ADC capture, feeder and filter.
// master drives the strobes, slave is the feeder.
interface lms_sample_feeder_if #(
  parameter int W1     = lms_pkg::W1,
  parameter int SKEW_W = lms_pkg::SKEW_W
);

  logic              x_vld;
  logic [W1-1:0]     x_smp;
  logic              d_vld;
  logic [W1-1:0]     d_smp;
  logic              align_req;
  logic              skew_ch;
  logic [SKEW_W-1:0] skew_n;
  logic              clr_flags;
  logic [W1-1:0]     x_out;
  logic [W1-1:0]     d_out;
  logic              pair_vld;
  logic              aligned;
  logic              ovf_x;
  logic              ovf_d;

  modport master (
    output x_vld, x_smp, d_vld, d_smp,
    output align_req, skew_ch, skew_n,
    output clr_flags,
    input  x_out, d_out, pair_vld,
    input  aligned, ovf_x, ovf_d
  );

  modport slave (
    input  x_vld, x_smp, d_vld, d_smp,
    input  align_req, skew_ch, skew_n,
    input  clr_flags,
    output x_out, d_out, pair_vld,
    output aligned, ovf_x, ovf_d
  );

endinterface

// File: rtl/lms_sample_feeder_fifo.sv
// Per-channel show-ahead sample FIFO.
// Flush empties it in one cycle and wins over push/pop.
module smp_fifo
  import lms_pkg::*;
#(
  parameter int W     = lms_pkg::W1,
  parameter int DEPTH = lms_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_FUL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & ~empty_o;
  assign full_o  = (cnt_q == C_FUL);
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // next pointers and occupancy
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + P_ONE;
      if (do_pop)  rd_d = rd_q + P_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + C_ONE;
        2'b01:   cnt_d = cnt_q - C_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // pointer/occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lms_sample_feeder.sv
// Pairs buffered x/d ADC streams for the LMS filter.
// Align FSM flushes and drops a skew from one channel.
module lms_sample_feeder
  import lms_pkg::*;
#(
  parameter int W1     = lms_pkg::W1,
  parameter int DEPTH  = lms_pkg::DEPTH,
  parameter int SKEW_W = lms_pkg::SKEW_W
) (
  input logic             clk,
  input logic             reset,
  lms_sample_feeder_if.slave bus
);

  localparam logic [SKEW_W-1:0] S_ONE = SKEW_W'(1);

  align_st_e         st_q, st_d;
  logic              skch_q, skch_d;
  logic [SKEW_W-1:0] dcnt_q, dcnt_d;
  logic              aligned_q, aligned_d;
  logic              ovfx_q, ovfx_d;
  logic              ovfd_q, ovfd_d;
  logic [W1-1:0]     xo_q, xo_d;
  logic [W1-1:0]     do_q, do_d;
  logic              pv_q, pv_d;

  logic [W1-1:0] x_dout, d_dout;
  logic          x_full, x_empty;
  logic          d_full, d_empty;
  logic          pop, flush;
  logic          x_take, d_take;
  logic          x_push, d_push;
  logic          x_ovf, d_ovf;
  logic          sel_vld;

  assign pop   = aligned_q & ~x_empty & ~d_empty;
  assign flush = (st_q == FLUSH);

  // in DISCARD the selected channel is consumed by the counter
  assign x_take = bus.x_vld & ~flush
                & ~((st_q == DISCARD) & ~skch_q);
  assign d_take = bus.d_vld & ~flush
                & ~((st_q == DISCARD) & skch_q);

  assign x_push = x_take & (~x_full | pop);
  assign d_push = d_take & (~d_full | pop);
  assign x_ovf  = x_take & x_full & ~pop;
  assign d_ovf  = d_take & d_full & ~pop;

  assign sel_vld = skch_q ? bus.d_vld : bus.x_vld;

  smp_fifo #(.W(W1), .DEPTH(DEPTH)) u_fx (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (x_push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (bus.x_smp),
    .dout_o  (x_dout),
    .full_o  (x_full),
    .empty_o (x_empty)
  );

  smp_fifo #(.W(W1), .DEPTH(DEPTH)) u_fd (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (d_push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (bus.d_smp),
    .dout_o  (d_dout),
    .full_o  (d_full),
    .empty_o (d_empty)
  );

  // align FSM next state, discard count and pairing enable
  always_comb begin
    st_d      = st_q;
    skch_d    = skch_q;
    dcnt_d    = dcnt_q;
    aligned_d = aligned_q;
    unique case (st_q)
      RUN: begin
      end
      FLUSH: begin
        if (dcnt_q == '0) begin
          st_d      = RUN;
          aligned_d = 1'b1;
        end else begin
          st_d = DISCARD;
        end
      end
      DISCARD: begin
        if (sel_vld) begin
          dcnt_d = dcnt_q - S_ONE;
          if (dcnt_q == S_ONE) begin
            st_d      = RUN;
            aligned_d = 1'b1;
          end
        end
      end
      default: st_d = RUN;
    endcase
    // a dropped sample breaks pairing until re-aligned
    if (x_ovf | d_ovf) aligned_d = 1'b0;
    if (bus.align_req) begin
      st_d      = FLUSH;
      skch_d    = bus.skew_ch;
      dcnt_d    = bus.skew_n;
      aligned_d = 1'b0;
    end
  end

  // sticky flags (set beats clear) and output pair
  always_comb begin
    ovfx_d = (ovfx_q & ~bus.clr_flags) | x_ovf;
    ovfd_d = (ovfd_q & ~bus.clr_flags) | d_ovf;
    xo_d   = xo_q;
    do_d   = do_q;
    pv_d   = pop;
    if (pop) begin
      xo_d = x_dout;
      do_d = d_dout;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= RUN;
      skch_q    <= 1'b0;
      dcnt_q    <= '0;
      aligned_q <= 1'b1;
      ovfx_q    <= 1'b0;
      ovfd_q    <= 1'b0;
      xo_q      <= '0;
      do_q      <= '0;
      pv_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      skch_q    <= skch_d;
      dcnt_q    <= dcnt_d;
      aligned_q <= aligned_d;
      ovfx_q    <= ovfx_d;
      ovfd_q    <= ovfd_d;
      xo_q      <= xo_d;
      do_q      <= do_d;
      pv_q      <= pv_d;
    end
  end

  assign bus.x_out    = xo_q;
  assign bus.d_out    = do_q;
  assign bus.pair_vld = pv_q;
  assign bus.aligned  = aligned_q;
  assign bus.ovf_x    = ovfx_q;
  assign bus.ovf_d    = ovfd_q;

endmodule

// File: tb/tb_lms_sample_feeder.sv
// Scoreboard bench for lms_sample_feeder.
// Queue-based reference model, monitor on negedge.
module tb_lms_sample_feeder;
  import lms_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lms_sample_feeder_if #(.W1(W1), .SKEW_W(SKEW_W)) bus ();

  lms_sample_feeder #(
    .W1(W1), .DEPTH(DEPTH), .SKEW_W(SKEW_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W1-1:0] x;
    logic [W1-1:0] d;
  } pair_t;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  logic [W1-1:0] qx[$];
  logic [W1-1:0] qd[$];
  pair_t         exp_q[$];
  bit            m_al = 1'b1;
  bit            m_ox = 1'b0;
  bit            m_od = 1'b0;
  bit            m_flush = 1'b0;
  int            m_left = 0;
  bit            m_ch = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)",
                  nm, act, want, $time);
  endtask

  // one input sample on one channel, in the model's terms
  task automatic take(input bit vld, input logic [W1-1:0] s,
                      input bit ch, inout logic [W1-1:0] q[$],
                      inout bit ovf, inout bit drop);
    if (!vld) return;
    if (m_left > 0 && m_ch == ch) begin
      m_left--;
      if (m_left == 0) m_al = 1'b1;
    end else if (q.size() < DEPTH) begin
      q.push_back(s);
    end else begin
      ovf  = 1'b1;
      drop = 1'b1;
    end
  endtask

  // reference model: one step per clock edge
  always @(posedge clk) begin
    if (!rst_n) begin
      qx.delete(); qd.delete(); exp_q.delete();
      m_al = 1'b1; m_ox = 1'b0; m_od = 1'b0;
      m_flush = 1'b0; m_left = 0; m_ch = 1'b0;
    end else begin
      bit drop;
      pair_t p;
      drop = 1'b0;
      if (m_al && qx.size() > 0 && qd.size() > 0) begin
        p.x = qx.pop_front();
        p.d = qd.pop_front();
        exp_q.push_back(p);
      end
      if (bus.clr_flags) begin
        m_ox = 1'b0;
        m_od = 1'b0;
      end
      if (m_flush) begin
        qx.delete();
        qd.delete();
        m_flush = 1'b0;
        if (m_left == 0) m_al = 1'b1;
      end else begin
        take(bus.x_vld, bus.x_smp, 1'b0, qx, m_ox, drop);
        take(bus.d_vld, bus.d_smp, 1'b1, qd, m_od, drop);
      end
      if (drop) m_al = 1'b0;
      if (bus.align_req) begin
        m_flush = 1'b1;
        m_al    = 1'b0;
        m_left  = int'(bus.skew_n);
        m_ch    = bus.skew_ch;
      end
    end
  end

  // monitor: compare status and pairs away from the edge
  logic [W1-1:0] last_x = '0;
  logic [W1-1:0] last_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_x = '0;
      last_d = '0;
    end else begin
      chk(bus.aligned === m_al, "aligned", 32'(bus.aligned), 32'(m_al));
      chk(bus.ovf_x === m_ox, "ovf_x", 32'(bus.ovf_x), 32'(m_ox));
      chk(bus.ovf_d === m_od, "ovf_d", 32'(bus.ovf_d), 32'(m_od));
      if (bus.pair_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pair", 32'(bus.x_out), 32'h0);
        end else begin
          pair_t p;
          p = exp_q.pop_front();
          chk(bus.x_out === p.x, "x_out", 32'(bus.x_out), 32'(p.x));
          chk(bus.d_out === p.d, "d_out", 32'(bus.d_out), 32'(p.d));
          last_x = p.x;
          last_d = p.d;
        end
      end else begin
        chk(exp_q.size() == 0, "missing_pair",
            32'(bus.pair_vld), 32'h1);
        chk(bus.x_out === last_x && bus.d_out === last_d, "hold",
            {bus.x_out, bus.d_out}, {last_x, last_d});
      end
    end
  end

  task automatic cyc(input bit xv, input logic [W1-1:0] xs,
                     input bit dv, input logic [W1-1:0] ds,
                     input bit ar = 1'b0, input bit clr = 1'b0);
    bus.x_vld     = xv;
    bus.x_smp     = xs;
    bus.d_vld     = dv;
    bus.d_smp     = ds;
    bus.align_req = ar;
    bus.clr_flags = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
  endtask

  task automatic realign(input bit ch, input int n);
    bus.skew_ch = ch;
    bus.skew_n  = SKEW_W'(n);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    bus.x_vld = 1'b0; bus.x_smp = '0;
    bus.d_vld = 1'b0; bus.d_smp = '0;
    bus.align_req = 1'b0; bus.skew_ch = 1'b0;
    bus.skew_n = '0; bus.clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus.x_out === '0, "rst_x_out", 32'(bus.x_out), 0);
    chk(bus.d_out === '0, "rst_d_out", 32'(bus.d_out), 0);
    chk(bus.pair_vld === 1'b0, "rst_pv", 32'(bus.pair_vld), 0);
    chk(bus.aligned === 1'b1, "rst_al", 32'(bus.aligned), 1);
    chk(bus.ovf_x === 1'b0 && bus.ovf_d === 1'b0, "rst_ovf",
        {bus.ovf_x, bus.ovf_d}, 0);
    rst_n = 1'b1;

    // lock-step streams
    for (int k = 1; k <= 20; k++)
      cyc(1'b1, W1'(k), 1'b1, W1'(-k));
    idle(3);

    // d lags x by three samples
    for (int i = 0; i < 23; i++)
      cyc(i < 20, W1'(i + 1), i >= 3, W1'(-(i - 2)));
    idle(4);

    // drop two x samples
    realign(1'b0, 2);
    for (int i = 0; i < 12; i++)
      cyc(1'b1, W1'(10 + i), 1'b1, W1'(-(10 + i)));
    idle(4);

    // overflow on x with d idle
    realign(1'b0, 0);
    for (int i = 0; i < 9; i++)
      cyc(1'b1, W1'(200 + i), 1'b0, '0);
    chk(bus.ovf_x === 1'b1, "ovf9_flag", 32'(bus.ovf_x), 1);
    chk(bus.aligned === 1'b0, "ovf9_al", 32'(bus.aligned), 0);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, '0, 1'b1, W1'(-(200 + i)));

    // clear alone, then clear racing a new drop
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk(bus.ovf_x === 1'b0, "clr_alone", 32'(bus.ovf_x), 0);
    cyc(1'b1, W1'(300), 1'b0, '0, 1'b0, 1'b1);
    chk(bus.ovf_x === 1'b1, "clr_vs_set", 32'(bus.ovf_x), 1);
    idle(2);

    // drop three d samples
    realign(1'b1, 3);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, W1'(400 + i), 1'b1, W1'(500 + i));
    idle(4);

    // reset with five words buffered
    realign(1'b0, 0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, W1'(600 + i), 1'b0, '0);
    rst_n = 1'b0;
    #1;
    chk(bus.x_out === '0 && bus.d_out === '0, "mid_rst_out",
        {bus.x_out, bus.d_out}, 0);
    chk(bus.pair_vld === 1'b0, "mid_rst_pv", 32'(bus.pair_vld), 0);
    chk(bus.aligned === 1'b1, "mid_rst_al", 32'(bus.aligned), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++)
      cyc(1'b1, W1'(700 + k), 1'b1, W1'(-(700 + k)));
    idle(3);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int px, pd;
      px = (i / 250) % 2 == 0 ? 70 : 40;
      pd = (i / 250) % 3 == 0 ? 35 : 65;
      bus.skew_ch = $urandom_range(0, 1) == 1;
      bus.skew_n  = SKEW_W'($urandom_range(0, 5));
      cyc($urandom_range(0, 99) < px, W1'($urandom),
          $urandom_range(0, 99) < pd, W1'($urandom),
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 79) == 0);
    end
    idle(6);
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
